// File: rtl/game_pkg.sv
// Shared game-wide constants and types used by the sprite, player, bullet and enemy blocks.
package game_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;
    localparam int unsigned NUM_COLS = 8;
    localparam int unsigned NUM_ROWS = 5;

    localparam int unsigned COORD_W  = 10;
    localparam int unsigned EDGE_W   = 11;
    localparam int unsigned COL_W    = 3;
    localparam int unsigned ALIVE_W  = 6;
    localparam int unsigned FCNT_W   = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MARCH   = 2'd1,
        ST_DESCEND = 2'd2,
        ST_LANDED  = 2'd3
    } march_state_t;

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the vsync-rate frame clock into the Clk domain and emits a one-cycle tick per rising edge.
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic frame_tick_c
);

    // [0],[1]: synchroniser; [2]: previous synchronised value for edge detection
    logic [2:0] sync_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], frame_clk};
        end
    end

    assign frame_tick_c = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/enemy_march_controller.sv
// Owns the invader formation origin and march direction; steps it every N frames, handles edges, clears and landing.
module enemy_march_controller
    import game_pkg::*;
#(
    parameter int unsigned FORM_X0      = 64,
    parameter int unsigned FORM_Y0      = 48,
    parameter int unsigned COL_PITCH    = 60,
    parameter int unsigned ENEMY_W      = 50,
    parameter int unsigned LEFT_MARGIN  = 8,
    parameter int unsigned RIGHT_MARGIN = 632,
    parameter int unsigned STEP_X       = 2,
    parameter int unsigned STEP_Y       = 16,
    parameter int unsigned BOTTOM_Y     = 400
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                frame_clk,
    input  logic                start,
    input  logic [ALIVE_W-1:0]  alive_count,
    input  logic [COL_W-1:0]    leftmost_col,
    input  logic [COL_W-1:0]    rightmost_col,
    output logic                enemy_direction_X,
    output logic                enemy_direction_Y,
    output logic [COORD_W-1:0]  formation_x,
    output logic [COORD_W-1:0]  formation_y,
    output logic                step_pulse,
    output logic                wave_cleared,
    output logic                invaders_landed
);

    logic frame_tick_c;

    frame_tick_sync u_frame_tick_sync (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .frame_tick_c (frame_tick_c)
    );

    march_state_t       state_q, state_d;
    logic               dir_x_q, dir_x_d;
    logic               dir_y_q, dir_y_d;
    logic [COORD_W-1:0] fx_q, fx_d;
    logic [COORD_W-1:0] fy_q, fy_d;
    logic               step_q, step_d;
    logic               cleared_q, cleared_d;
    logic               landed_q, landed_d;
    logic [FCNT_W-1:0]  cnt_q, cnt_d;

    logic [FCNT_W-1:0]  period;
    logic [FCNT_W-1:0]  cnt_inc;
    logic               step_due;
    logic [EDGE_W-1:0]  right_sum;
    logic [EDGE_W-1:0]  left_sum;
    logic               right_hit;
    logic               left_hit;
    logic               edge_hit;
    logic [COORD_W-1:0] fy_down;

    // Step cadence and edge geometry, all derived from current registers and inputs
    always_comb begin
        period    = FCNT_W'(alive_count[ALIVE_W-1:1]) + FCNT_W'(1);
        cnt_inc   = cnt_q + FCNT_W'(1);
        step_due  = frame_tick_c && (cnt_inc >= period);
        right_sum = EDGE_W'(fx_q) + EDGE_W'(rightmost_col) * EDGE_W'(COL_PITCH)
                  + EDGE_W'(ENEMY_W) + EDGE_W'(STEP_X);
        left_sum  = EDGE_W'(fx_q) + EDGE_W'(leftmost_col) * EDGE_W'(COL_PITCH);
        right_hit = right_sum > EDGE_W'(RIGHT_MARGIN);
        left_hit  = left_sum < EDGE_W'(LEFT_MARGIN + STEP_X);
        edge_hit  = dir_x_q ? right_hit : left_hit;
        fy_down   = fy_q + COORD_W'(STEP_Y);
    end

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        dir_x_d   = dir_x_q;
        dir_y_d   = dir_y_q;
        fx_d      = fx_q;
        fy_d      = fy_q;
        step_d    = 1'b0;
        cleared_d = 1'b0;
        landed_d  = landed_q;
        cnt_d     = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_MARCH;
                    fx_d     = COORD_W'(FORM_X0);
                    fy_d     = COORD_W'(FORM_Y0);
                    dir_x_d  = 1'b1;
                    dir_y_d  = 1'b0;
                    cnt_d    = '0;
                    landed_d = 1'b0;
                end
            end
            ST_MARCH: begin
                if (alive_count == '0) begin
                    cleared_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (frame_tick_c) begin
                    cnt_d = step_due ? '0 : cnt_inc;
                    if (step_due) begin
                        step_d = 1'b1;
                        if (edge_hit) begin
                            dir_y_d = 1'b1;
                            state_d = ST_DESCEND;
                        end else if (dir_x_q) begin
                            fx_d = fx_q + COORD_W'(STEP_X);
                        end else begin
                            fx_d = fx_q - COORD_W'(STEP_X);
                        end
                    end
                end
            end
            ST_DESCEND: begin
                if (alive_count == '0) begin
                    cleared_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (frame_tick_c) begin
                    cnt_d = step_due ? '0 : cnt_inc;
                    if (step_due) begin
                        step_d  = 1'b1;
                        fy_d    = fy_down;
                        dir_x_d = ~dir_x_q;
                        dir_y_d = 1'b0;
                        if (fy_down >= COORD_W'(BOTTOM_Y)) begin
                            state_d  = ST_LANDED;
                            landed_d = 1'b1;
                        end else begin
                            state_d = ST_MARCH;
                        end
                    end
                end
            end
            ST_LANDED: begin
                state_d = ST_LANDED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_IDLE;
            dir_x_q   <= 1'b1;
            dir_y_q   <= 1'b0;
            fx_q      <= COORD_W'(FORM_X0);
            fy_q      <= COORD_W'(FORM_Y0);
            step_q    <= 1'b0;
            cleared_q <= 1'b0;
            landed_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            fx_q      <= fx_d;
            fy_q      <= fy_d;
            step_q    <= step_d;
            cleared_q <= cleared_d;
            landed_q  <= landed_d;
            cnt_q     <= cnt_d;
        end
    end

    assign enemy_direction_X = dir_x_q;
    assign enemy_direction_Y = dir_y_q;
    assign formation_x       = fx_q;
    assign formation_y       = fy_q;
    assign step_pulse        = step_q;
    assign wave_cleared      = cleared_q;
    assign invaders_landed   = landed_q;

endmodule

// File: doc/enemy_march_controller.md
Name: enemy_march_controller

Overview:
- Upstream of each enemy sprite drawer: owns the invader formation's position and march direction.
- Produces enemy_direction_X / enemy_direction_Y plus the formation origin that every enemy instance offsets from.
- Steps the formation once every N frames, with N shrinking as invaders die.
- Detects screen-edge collisions (drop a row, reverse), a cleared wave and invaders reaching the bottom.

Parameters:
- FORM_X0, 64: formation origin X after start.
- FORM_Y0, 48: formation origin Y after start.
- COL_PITCH, 60: X distance between enemy columns, px.
- ENEMY_W, 50: enemy sprite width, px.
- LEFT_MARGIN, 8: leftmost legal pixel of any enemy.
- RIGHT_MARGIN, 632: rightmost legal pixel +1.
- STEP_X, 2: horizontal px per step.
- STEP_Y, 16: vertical px per descent.
- BOTTOM_Y, 400: origin Y at or beyond which invaders have landed.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- frame_clk  in  1  vsync-rate frame clock, treated as data; synchronised internally.
- start  in  1  level; begins a wave from IDLE.
- alive_count  in  6  live invaders, 0..40.
- leftmost_col  in  3  lowest column index with a live invader.
- rightmost_col  in  3  highest column index with a live invader.
- enemy_direction_X  out  1  0 = moving left, 1 = moving right.
- enemy_direction_Y  out  1  1 = a descent is pending or occurring.
- formation_x  out  10  formation origin X.
- formation_y  out  10  formation origin Y.
- step_pulse  out  1  one Clk-cycle pulse on every executed step (audio/animation).
- wave_cleared  out  1  one-cycle pulse when alive_count reaches 0 while marching.
- invaders_landed  out  1  sticky until reset or start.

Behaviour:
- Reset (async, Reset=0) values:
  - state = IDLE.
  - enemy_direction_X = 1, enemy_direction_Y = 0.
  - formation_x = FORM_X0, formation_y = FORM_Y0.
  - step_pulse = 0, wave_cleared = 0, invaders_landed = 0.
  - frame counter = 0; synchroniser flops = 0.
- Frame tick:
  - frame_clk passes through a 2-flop synchroniser.
  - A rising edge of the synchronised signal yields frame_tick, exactly one Clk cycle wide.
  - Latency is 3 Clk cycles from the frame_clk edge.
- Step period: period = alive_count[5:1] + 1 frames, re-evaluated every tick.
  - The frame counter increments on each frame_tick.
  - When counter+1 >= period, the counter clears to 0 and a step fires in that same cycle.
- Edge checks use 11-bit unsigned arithmetic.
  - right_hit = formation_x + rightmost_col*COL_PITCH + ENEMY_W + STEP_X > RIGHT_MARGIN.
  - left_hit = formation_x + leftmost_col*COL_PITCH < LEFT_MARGIN + STEP_X.
- FSM states: IDLE, MARCH, DESCEND, LANDED.
  - IDLE: on start = 1, load the origin, direction_X = 1, direction_Y = 0, counter = 0, clear invaders_landed, then go to MARCH. Frame ticks are ignored.
  - MARCH, step with (dir = 1 and right_hit) or (dir = 0 and left_hit): X unchanged, direction_Y = 1, go to DESCEND, step_pulse = 1.
  - MARCH, other step: formation_x ± STEP_X, step_pulse = 1.
  - DESCEND, next step: formation_y += STEP_Y, invert direction_X, direction_Y = 0, step_pulse = 1.
    - If the new formation_y >= BOTTOM_Y, go to LANDED and set invaders_landed.
    - Otherwise go to MARCH.
  - LANDED: outputs frozen; return to IDLE only via reset. start is ignored.
- Priority, highest first: reset > alive_count == 0 > step.
  - alive_count == 0 in MARCH or DESCEND: wave_cleared pulses for 1 cycle, go to IDLE, formation registers hold, no step taken that cycle.
  - In IDLE, alive_count is ignored.
- start asserted outside IDLE is ignored; start held high across a clear restarts the wave on the cycle after IDLE is entered.
- leftmost_col and rightmost_col are don't-care when alive_count == 0.
- A reset mid-step cancels everything; pulses drop immediately.
- All outputs are registered.

Decomposition:
- Shared package game_pkg:
  - march_state_t enum.
  - Screen constants SCREEN_W = 640, SCREEN_H = 480, shared with the sprite drawers.
  - NUM_COLS = 8, NUM_ROWS = 5.
- One sub-module: frame_tick_sync (2-flop synchroniser plus rising-edge detector). Reused by the player and bullet blocks.

Test Plan:
- Reset: hold Reset = 0 → dir_X = 1, dir_Y = 0, formation = (64, 48), all pulses 0, state IDLE.
- Basic march: start = 1, alive_count = 2 (period 2), 4 frame_clk edges → formation_x = 68, two step_pulses, each 1 cycle wide, landing 3 Clk cycles after the 2nd and 4th edges.
- Right edge:
  - Setup: alive = 1 (period 1), cols 0..7, march until formation_x = 162.
  - Next tick → DESCEND, dir_Y = 1, x stays 162.
  - Next tick → formation_y = 64, dir_X = 0, dir_Y = 0.
- Left edge: leftmost_col = 0, march left until formation_x = 8 → next tick descends; no step ever leaves formation_x < 8.
- Landing: force formation_y = 384 via repeated descents → the descent to 400 asserts invaders_landed and enters LANDED; further ticks and start change nothing until Reset = 0.
- Clear vs step: alive_count drops to 0 in the same cycle as a step → wave_cleared = 1 for one cycle, no step_pulse, formation unchanged, state IDLE.
